// File: rtl/ir_packet_tx_pkg.sv
// ============================================================================
// Module  : ir_packet_tx_pkg
// Brief   : Shared car timing types, per-car constants and IR packet states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ir_packet_tx_pkg;

    localparam int CAR_COUNT = 4;
    localparam int FIELD_W   = 16;

    typedef struct packed {
        logic [FIELD_W-1:0] carrier_half_period;
        logic [FIELD_W-1:0] start_burst;
        logic [FIELD_W-1:0] car_select_burst;
        logic [FIELD_W-1:0] gap_size;
        logic [FIELD_W-1:0] assert_burst;
        logic [FIELD_W-1:0] deassert_burst;
    } CarSettings;

    // 38 kHz carrier at 100 MHz; cars differ only in their select burst length.
    localparam CarSettings CAR0_PARAMS = '{carrier_half_period: 16'd1316, start_burst: 16'd24,
        car_select_burst: 16'd4, gap_size: 16'd4, assert_burst: 16'd8, deassert_burst: 16'd4};
    localparam CarSettings CAR1_PARAMS = '{carrier_half_period: 16'd1316, start_burst: 16'd24,
        car_select_burst: 16'd8, gap_size: 16'd4, assert_burst: 16'd8, deassert_burst: 16'd4};
    localparam CarSettings CAR2_PARAMS = '{carrier_half_period: 16'd1316, start_burst: 16'd24,
        car_select_burst: 16'd12, gap_size: 16'd4, assert_burst: 16'd8, deassert_burst: 16'd4};
    localparam CarSettings CAR3_PARAMS = '{carrier_half_period: 16'd1316, start_burst: 16'd24,
        car_select_burst: 16'd16, gap_size: 16'd4, assert_burst: 16'd8, deassert_burst: 16'd4};

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        GAP0   = 4'd2,
        SELECT = 4'd3,
        GAP1   = 4'd4,
        RIGHT  = 4'd5,
        GAP2   = 4'd6,
        LEFT   = 4'd7,
        GAP3   = 4'd8,
        BACK   = 4'd9,
        GAP4   = 4'd10,
        FWD    = 4'd11,
        GAP5   = 4'd12
    } IrTxState;

    function automatic IrTxState next_state(input IrTxState s);
        IrTxState n;
        case (s)
            START:   n = GAP0;
            GAP0:    n = SELECT;
            SELECT:  n = GAP1;
            GAP1:    n = RIGHT;
            RIGHT:   n = GAP2;
            GAP2:    n = LEFT;
            LEFT:    n = GAP3;
            GAP3:    n = BACK;
            BACK:    n = GAP4;
            GAP4:    n = FWD;
            FWD:     n = GAP5;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    function automatic logic is_burst(input IrTxState s);
        return (s == START) || (s == SELECT) || (s == RIGHT) ||
               (s == LEFT)  || (s == BACK)   || (s == FWD);
    endfunction

    // Length in carrier periods of state s; a zero field still lasts one period.
    function automatic logic [FIELD_W-1:0] burst_len(input IrTxState s, input CarSettings c,
                                                     input logic [3:0] cmd);
        logic [FIELD_W-1:0] len;
        case (s)
            START:   len = c.start_burst;
            SELECT:  len = c.car_select_burst;
            RIGHT:   len = cmd[3] ? c.assert_burst : c.deassert_burst;
            LEFT:    len = cmd[2] ? c.assert_burst : c.deassert_burst;
            BACK:    len = cmd[1] ? c.assert_burst : c.deassert_burst;
            FWD:     len = cmd[0] ? c.assert_burst : c.deassert_burst;
            default: len = c.gap_size;
        endcase
        return (len == '0) ? FIELD_W'(1) : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ir_carrier_gen.sv
// ============================================================================
// Module  : ir_carrier_gen
// Brief   : Square-wave carrier starting high; flags the last clock of a period.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_carrier_gen
    import ir_packet_tx_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               restart,
    input  logic [FIELD_W-1:0] half_period,
    output logic               phase,
    output logic               period_end
);

    logic [FIELD_W-1:0] r_count;
    logic [FIELD_W-1:0] w_half_m1;
    logic               w_terminal;

    assign w_half_m1  = (half_period == '0) ? '0 : half_period - 1'b1;
    assign w_terminal = (r_count == w_half_m1);
    assign period_end = w_terminal && !phase;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            phase   <= 1'b1;
        end else if (restart) begin
            r_count <= '0;
            phase   <= 1'b1;
        end else if (w_terminal) begin
            r_count <= '0;
            phase   <= ~phase;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ir_packet_tx.sv
// ============================================================================
// Module  : ir_packet_tx
// Brief   : Periodic IR car packet transmitter (bursts and gaps of a carrier).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_packet_tx
    import ir_packet_tx_pkg::*;
#(
    parameter int PACKET_PERIOD_CYCLES = 10_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  CarSettings car,
    input  logic [3:0] command,
    output logic       ir_led,
    output logic       busy,
    output logic       packet_done
);

    localparam int FRAME_W = (PACKET_PERIOD_CYCLES > 1) ? $clog2(PACKET_PERIOD_CYCLES) : 1;
    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(PACKET_PERIOD_CYCLES - 1);

    logic [FRAME_W-1:0] r_frame_cnt;
    IrTxState           r_state;
    CarSettings         r_car;
    logic [3:0]         r_cmd;
    logic [FIELD_W-1:0] r_period_cnt;

    logic               w_tick;
    logic               w_start;
    logic               w_advance;
    logic               w_restart;
    logic               w_phase;
    logic               w_period_end;
    logic [FIELD_W-1:0] w_len;

    assign w_tick    = (r_frame_cnt == c_frame_last);
    assign w_start   = (r_state == IDLE) && w_tick;
    assign w_len     = burst_len(r_state, r_car, r_cmd);
    assign w_advance = (r_state != IDLE) && w_period_end && (r_period_cnt == w_len - 1'b1);
    // Holding the carrier in restart while idle makes START begin at phase 1, count 0.
    assign w_restart = (r_state == IDLE) || w_advance;

    assign packet_done = w_advance && (r_state == GAP5);

    ir_carrier_gen u_carrier (
        .CLK        (CLK),
        .RESET      (RESET),
        .restart    (w_restart),
        .half_period(r_car.carrier_half_period),
        .phase      (w_phase),
        .period_end (w_period_end)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_frame_cnt  <= '0;
            r_state      <= IDLE;
            r_car        <= '0;
            r_cmd        <= '0;
            r_period_cnt <= '0;
            busy         <= 1'b0;
            ir_led       <= 1'b0;
        end else begin
            r_frame_cnt <= w_tick ? '0 : r_frame_cnt + 1'b1;
            ir_led      <= is_burst(r_state) && w_phase;

            if (w_start) begin
                r_car        <= car;
                r_cmd        <= command;
                r_state      <= START;
                r_period_cnt <= '0;
                busy         <= 1'b1;
            end else if (w_advance) begin
                r_state      <= next_state(r_state);
                r_period_cnt <= '0;
                if (r_state == GAP5) begin
                    busy <= 1'b0;
                end
            end else if (w_period_end && (r_state != IDLE)) begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ir_packet_tx.sv
// ============================================================================
// Module  : tb_ir_packet_tx
// Brief   : Directed vector table plus corner sequences for ir_packet_tx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ir_packet_tx;
    import ir_packet_tx_pkg::*;

    localparam int P = 200;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    CarSettings car;
    logic [3:0] command;
    logic       ir_led;
    logic       busy;
    logic       packet_done;

    ir_packet_tx #(.PACKET_PERIOD_CYCLES(P)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .car        (car),
        .command    (command),
        .ir_led     (ir_led),
        .busy       (busy),
        .packet_done(packet_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic trace [0:511];

    typedef struct {
        int blen, high, runs, done_n, done_idx, first_hi, rise_cyc, wait_n, pre_done;
    } res_t;

    typedef struct {
        CarSettings car;
        logic [3:0] cmd;
        int         exp_len;
        int         exp_high;
        int         exp_runs;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic CarSettings mk_car(input int h, input int s, input int sel,
                                          input int g, input int a, input int d);
        CarSettings c;
        c.carrier_half_period = FIELD_W'(h);
        c.start_burst         = FIELD_W'(s);
        c.car_select_burst    = FIELD_W'(sel);
        c.gap_size            = FIELD_W'(g);
        c.assert_burst        = FIELD_W'(a);
        c.deassert_burst      = FIELD_W'(d);
        return c;
    endfunction

    // Called at a negedge with busy low; samples one whole packet on negedges.
    task automatic capture(input int mid_idx, input CarSettings mid_car,
                           input logic [3:0] mid_cmd, output res_t r);
        int   idx;
        logic prev;
        r = '{default: 0};
        r.first_hi = -1;
        r.done_idx = -1;
        while (!busy && r.wait_n < 400) begin
            if (packet_done) r.pre_done++;
            @(negedge CLK);
            r.wait_n++;
        end
        if (!busy) begin
            check("busy_rise_timeout", 0, 1);
            return;
        end
        r.rise_cyc = cyc;
        idx  = 0;
        prev = 1'b0;
        while (busy && idx < 512) begin
            trace[idx] = ir_led;
            if (ir_led) begin
                r.high++;
                if (r.first_hi < 0) r.first_hi = idx;
                if (!prev) r.runs++;
            end
            prev = ir_led;
            if (packet_done) begin
                r.done_n++;
                r.done_idx = idx;
            end
            if (idx == mid_idx) begin
                car     = mid_car;
                command = mid_cmd;
            end
            @(negedge CLK);
            idx++;
        end
        r.blen = idx;
    endtask

    task automatic check_packet(input string tag, input res_t r, input int exp_len,
                                input int exp_high, input int exp_runs);
        check({tag, "_busy_len"}, r.blen, exp_len);
        check({tag, "_led_high"}, r.high, exp_high);
        check({tag, "_led_runs"}, r.runs, exp_runs);
        check({tag, "_done_cnt"}, r.done_n, 1);
        check({tag, "_done_idx"}, r.done_idx, exp_len - 1);
        check({tag, "_first_hi"}, r.first_hi, 1);
    endtask

    initial begin
        vec_t       vecs [6];
        res_t       r;
        int         prev_rise;
        int         n;
        int         pd;
        logic [15:0] start_bits;
        CarSettings car_a, car_b, car_c;

        car_a = mk_car(2, 3, 2, 1, 2, 1);
        car_b = mk_car(0, 0, 0, 0, 0, 0);
        car_c = mk_car(3, 1, 1, 2, 3, 0);

        // Lengths: busy clocks = periods * 2 * half; high clocks = burst periods * half.
        vecs[0] = '{car_a, 4'b0101,  68, 22, 11};
        vecs[1] = '{car_a, 4'b0000,  60, 18,  9};
        vecs[2] = '{car_a, 4'b1111,  76, 26, 13};
        vecs[3] = '{car_a, 4'b1010,  68, 22, 11};
        vecs[4] = '{car_b, 4'b1111,  24,  6,  6};
        vecs[5] = '{car_c, 4'b0001, 120, 24,  8};

        car     = car_a;
        command = 4'b0101;
        RESET   = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_ir_led", int'(ir_led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_packet_done", int'(packet_done), 0);
        RESET = 1'b0;

        prev_rise = -1;
        for (int i = 0; i < 6; i++) begin
            car     = vecs[i].car;
            command = vecs[i].cmd;
            capture(-1, car, command, r);
            check_packet($sformatf("vec%0d", i), r, vecs[i].exp_len, vecs[i].exp_high,
                         vecs[i].exp_runs);
            if (i == 0) begin
                // Tick at count 199, busy visible after the following edge.
                check("first_packet_wait", r.wait_n, 200);
                for (int k = 0; k < 16; k++) start_bits[15-k] = trace[k+1];
                check("start_carrier_pattern", int'(start_bits), int'(16'b1100110011000000));
            end else begin
                check($sformatf("vec%0d_frame_spacing", i), r.rise_cyc - prev_rise, P);
            end
            prev_rise = r.rise_cyc;
        end

        // Inputs changed during SELECT must not affect the packet in flight.
        car     = car_a;
        command = 4'b0101;
        capture(17, car_c, 4'b1111, r);
        check_packet("midchg_cur", r, 68, 22, 11);
        check("midchg_cur_spacing", r.rise_cyc - prev_rise, P);
        prev_rise = r.rise_cyc;
        capture(-1, car, command, r);
        check_packet("midchg_next", r, 156, 42, 14);
        check("midchg_next_spacing", r.rise_cyc - prev_rise, P);

        // Reset in the middle of LEFT (trace index 38 is LEFT's second clock).
        car     = car_a;
        command = 4'b0101;
        n = 0;
        while (!busy && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("rst_seq_busy_rise", int'(busy), 1);
        pd = 0;
        for (int k = 0; k < 38; k++) begin
            if (packet_done) pd++;
            @(negedge CLK);
        end
        check("rst_seq_led_before", int'(ir_led), 1);
        RESET = 1'b1;
        #1;
        check("rst_mid_ir_led", int'(ir_led), 0);
        check("rst_mid_busy", int'(busy), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            if (packet_done) pd++;
        end
        check("rst_mid_no_done", pd, 0);
        RESET = 1'b0;
        capture(-1, car, command, r);
        check("rst_release_wait", r.wait_n, 200);
        check("rst_release_no_done", r.pre_done, 0);
        check_packet("rst_next", r, 68, 22, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
